// File: rtl/logic_op_arbiter.sv
// Two-requester round-robin front end for one shared 32-bit bitwise logic unit,
// with a one-entry registered result buffer toward the writeback path.
module logic_op_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_data,
    output logic [7:0]       grant_count0,
    output logic [7:0]       grant_count1
);

    logic             resp_valid_q, resp_valid_d;
    logic             resp_id_q, resp_id_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;
    logic [7:0]       grant_count0_q, grant_count0_d;
    logic [7:0]       grant_count1_q, grant_count1_d;
    logic             ptr_q, ptr_d;

    logic can_accept;
    logic grant0, grant1;
    logic acc0, acc1;

    function automatic logic [WIDTH-1:0] logic_op(
        input logic [1:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        unique case (op)
            2'b00:   r = a & b;
            2'b01:   r = a | b;
            2'b10:   r = a ^ b;
            default: r = ~(a | b);
        endcase
        return r;
    endfunction

    always_comb begin
        can_accept = !resp_valid_q || resp_ready;
        // Pointer only breaks ties; a lone requester always wins.
        grant0     = req0_valid && (!req1_valid || !ptr_q);
        grant1     = req1_valid && (!req0_valid || ptr_q);
        req0_ready = can_accept && grant0 && !reset;
        req1_ready = can_accept && grant1 && !reset;
        acc0       = req0_valid && req0_ready;
        acc1       = req1_valid && req1_ready;
    end

    always_comb begin
        resp_valid_d   = resp_valid_q;
        resp_id_d      = resp_id_q;
        resp_data_d    = resp_data_q;
        grant_count0_d = grant_count0_q;
        grant_count1_d = grant_count1_q;
        ptr_d          = ptr_q;
        if (resp_valid_q && resp_ready) begin
            resp_valid_d = 1'b0;
        end
        if (acc0) begin
            resp_valid_d = 1'b1;
            resp_id_d    = 1'b0;
            resp_data_d  = logic_op(req0_op, req0_a, req0_b);
            ptr_d        = 1'b1;
            if (grant_count0_q != 8'hFF) begin
                grant_count0_d = grant_count0_q + 8'd1;
            end
        end else if (acc1) begin
            resp_valid_d = 1'b1;
            resp_id_d    = 1'b1;
            resp_data_d  = logic_op(req1_op, req1_a, req1_b);
            ptr_d        = 1'b0;
            if (grant_count1_q != 8'hFF) begin
                grant_count1_d = grant_count1_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid_q   <= 1'b0;
            resp_id_q      <= 1'b0;
            resp_data_q    <= '0;
            grant_count0_q <= 8'd0;
            grant_count1_q <= 8'd0;
            ptr_q          <= 1'b0;
        end else begin
            resp_valid_q   <= resp_valid_d;
            resp_id_q      <= resp_id_d;
            resp_data_q    <= resp_data_d;
            grant_count0_q <= grant_count0_d;
            grant_count1_q <= grant_count1_d;
            ptr_q          <= ptr_d;
        end
    end

    assign resp_valid   = resp_valid_q;
    assign resp_id      = resp_id_q;
    assign resp_data    = resp_data_q;
    assign grant_count0 = grant_count0_q;
    assign grant_count1 = grant_count1_q;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Bench for logic_op_arbiter: opcode table, directed handshake sequences
// and randomized traffic against a behavioural arbiter/buffer model.
module tb_logic_op_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [1:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        resp_valid, resp_ready, resp_id;
    logic [31:0] resp_data;
    logic [7:0]  grant_count0, grant_count1;

    logic_op_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data),
        .grant_count0(grant_count0), .grant_count1(grant_count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model of the buffer, pointer and counters
    logic        m_valid;
    logic        m_id;
    logic [31:0] m_data;
    int          m_ptr;
    int          m_cnt [2];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    // Drive one cycle's inputs after the falling edge, check against the model,
    // then advance the model to what the next rising edge should produce.
    task automatic step(input logic rst, input logic v0, input logic [1:0] o0,
                        input logic [31:0] a0, input logic [31:0] b0,
                        input logic v1, input logic [1:0] o1,
                        input logic [31:0] a1, input logic [31:0] b1,
                        input logic rr);
        logic [1:0] er;
        int nv, w;
        @(negedge clk);
        reset = rst;
        req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
        resp_ready = rr;
        #1;
        er = 2'b00;
        nv = int'(v0) + int'(v1);
        w  = (nv == 1) ? (v1 ? 1 : 0) : m_ptr;
        if (!rst && nv > 0 && (!m_valid || rr)) er[w] = 1'b1;
        chk("rdy0", 32'(req0_ready), 32'(er[0]));
        chk("rdy1", 32'(req1_ready), 32'(er[1]));
        chk("valid", 32'(resp_valid), 32'(m_valid));
        if (m_valid) begin
            chk("id", 32'(resp_id), 32'(m_id));
            chk("data", resp_data, m_data);
        end
        chk("cnt0", 32'(grant_count0), 32'(m_cnt[0]));
        chk("cnt1", 32'(grant_count1), 32'(m_cnt[1]));
        if (rst) begin
            m_valid = 1'b0; m_id = 1'b0; m_data = '0; m_ptr = 0;
            m_cnt[0] = 0; m_cnt[1] = 0;
        end else begin
            if (m_valid && rr) m_valid = 1'b0;
            if (er != 2'b00) begin
                m_valid = 1'b1;
                m_id    = (w == 1);
                m_data  = (w == 1) ? ref_op(o1, a1, b1) : ref_op(o0, a0, b0);
                m_ptr   = 1 - w;
                if (m_cnt[w] < 255) m_cnt[w]++;
            end
        end
    endtask

    task automatic idle(input logic rr);
        step(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 2'd0, 32'h0, 32'h0, rr);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic both(input logic rr);
        step(1'b0, 1'b1, 2'd0, 32'hF0F0_F0F0, 32'hFF00_FF00,
             1'b1, 2'd2, 32'hAAAA_AAAA, 32'hFFFF_FFFF, rr);
    endtask

    vec_t tbl [10];

    initial begin
        m_valid = 1'b0; m_id = 1'b0; m_data = '0; m_ptr = 0;
        m_cnt[0] = 0; m_cnt[1] = 0;
        reset = 1'b1; resp_ready = 1'b0;
        req0_valid = 1'b0; req0_op = 2'd0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = 2'd0; req1_a = '0; req1_b = '0;

        tbl[0] = '{2'd0, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000};
        tbl[1] = '{2'd1, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hFFFF_0F0F};
        tbl[2] = '{2'd2, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F};
        tbl[3] = '{2'd3, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0000_F0F0};
        tbl[4] = '{2'd0, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[5] = '{2'd1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        tbl[6] = '{2'd2, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0000_0000};
        tbl[7] = '{2'd3, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
        tbl[8] = '{2'd2, 32'h1234_5678, 32'hFFFF_FFFF, 32'hEDCB_A987};
        tbl[9] = '{2'd0, 32'h8000_0001, 32'hFFFF_FFFF, 32'h8000_0001};

        do_reset();
        do_reset();
        idle(1'b0);
        chk("rst_valid", 32'(resp_valid), 32'h0);
        chk("rst_id", 32'(resp_id), 32'h0);
        chk("rst_data", resp_data, 32'h0);
        chk("rst_cnt0", 32'(grant_count0), 32'h0);
        chk("rst_cnt1", 32'(grant_count1), 32'h0);

        // NOR on requester 0, one-cycle latency
        step(1'b0, 1'b1, 2'd3, 32'h0, 32'h0000_00FF, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
        chk("nor_rdy", 32'(req0_ready), 32'h1);
        idle(1'b1);
        chk("nor_valid", 32'(resp_valid), 32'h1);
        chk("nor_id", 32'(resp_id), 32'h0);
        chk("nor_data", resp_data, 32'hFFFF_FF00);
        chk("nor_cnt0", 32'(grant_count0), 32'h1);

        // Opcode table, alternating lone requesters
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) begin
                if (i % 2 == 0)
                    step(1'b0, 1'b1, tbl[i].op, tbl[i].a, tbl[i].b,
                         1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
                else
                    step(1'b0, 1'b0, 2'd0, 32'h0, 32'h0,
                         1'b1, tbl[i].op, tbl[i].a, tbl[i].b, 1'b1);
            end else begin
                idle(1'b1);
            end
            if (i > 0) begin
                chk("tbl_data", resp_data, tbl[i-1].exp);
                chk("tbl_id", 32'(resp_id), 32'((i - 1) % 2));
            end
        end

        // Both valid: grants alternate starting at requester 0
        do_reset();
        for (int i = 0; i < 5; i++) begin
            both(1'b1);
            chk("alt_rdy0", 32'(req0_ready), 32'(i % 2 == 0));
            chk("alt_rdy1", 32'(req1_ready), 32'(i % 2 == 1));
            if (i > 0) begin
                chk("alt_id", 32'(resp_id), 32'((i - 1) % 2));
                chk("alt_data", resp_data, ((i - 1) % 2 == 0) ? 32'hF000_F000 : 32'h5555_5555);
            end
        end

        // Stall with both valid, then release with no bubble
        do_reset();
        both(1'b1);
        for (int i = 0; i < 3; i++) begin
            both(1'b0);
            chk("stall_rdy0", 32'(req0_ready), 32'h0);
            chk("stall_rdy1", 32'(req1_ready), 32'h0);
            chk("stall_id", 32'(resp_id), 32'h0);
            chk("stall_data", resp_data, 32'hF000_F000);
        end
        both(1'b1);
        chk("rel_rdy1", 32'(req1_ready), 32'h1);
        both(1'b1);
        chk("rel_valid", 32'(resp_valid), 32'h1);
        chk("rel_id", 32'(resp_id), 32'h1);
        chk("rel_data", resp_data, 32'h5555_5555);

        // Lone requester 1 for 300 cycles: counter saturates
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'b0, 2'd0, 32'h0, 32'h0,
                 1'b1, 2'(i), $urandom, $urandom, 1'b1);
            chk("sat_rdy1", 32'(req1_ready), 32'h1);
        end
        idle(1'b1);
        chk("sat_cnt1", 32'(grant_count1), 32'd255);
        chk("sat_cnt0", 32'(grant_count0), 32'd0);

        // Reset while the buffer is full and both are valid
        both(1'b1);
        both(1'b0);
        step(1'b1, 1'b1, 2'd0, 32'hF0F0_F0F0, 32'hFF00_FF00,
             1'b1, 2'd2, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 1'b1);
        chk("rstmid_rdy0", 32'(req0_ready), 32'h0);
        chk("rstmid_rdy1", 32'(req1_ready), 32'h0);
        both(1'b1);
        chk("rstmid_valid", 32'(resp_valid), 32'h0);
        chk("rstmid_cnt0", 32'(grant_count0), 32'h0);
        chk("rstmid_cnt1", 32'(grant_count1), 32'h0);
        chk("rstmid_first", 32'(req0_ready), 32'h1);

        // OR result held through one stall cycle and consumed once
        do_reset();
        step(1'b0, 1'b1, 2'd1, 32'h1234_0000, 32'h0000_5678, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
        idle(1'b0);
        chk("or_valid", 32'(resp_valid), 32'h1);
        chk("or_data", resp_data, 32'h1234_5678);
        idle(1'b1);
        chk("or_held", resp_data, 32'h1234_5678);
        chk("or_held_v", 32'(resp_valid), 32'h1);
        idle(1'b1);
        chk("or_gone", 32'(resp_valid), 32'h0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 49) == 0),
                 1'($urandom), 2'($urandom), $urandom, $urandom,
                 1'($urandom), 2'($urandom), $urandom, $urandom,
                 1'($urandom_range(0, 3) != 0));
        end
        idle(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
